// File: rtl/score_level.sv
// score_level: line-clear scoring and thermometer level controller for the gravity tick generator.
// Optional back-to-back 4-line bonus when SCORE_LEVEL_B2B_EN is defined.
module score_level #(
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL = 5
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        new_game,
  input  logic        clr_valid,
  input  logic [2:0]  clr_lines,
  output logic        clr_ready,
  output logic [4:0]  score,
  output logic [2:0]  level,
  output logic [9:0]  total_lines,
  output logic [15:0] points,
  output logic        level_up
);
  typedef enum logic [1:0] {IDLE, ADD, UPD} state_t;
  state_t state;
  logic [2:0] n_in, n_q, iter;
  logic [3:0] base_in, base_q;
  logic [5:0] lines_in_level;
  logic [16:0] pts_sum;
  logic [10:0] tot_sum;
  logic [6:0] lil_sum;
  assign n_in = clr_lines > 3'd4 ? 3'd4 : clr_lines;
`ifdef SCORE_LEVEL_B2B_EN
  logic b2b;
  assign base_in = n_in == 3'd4 ? (b2b ? 4'd12 : 4'd8) : {n_in, 1'b0} - 4'd1;
`else
  assign base_in = n_in == 3'd4 ? 4'd8 : {n_in, 1'b0} - 4'd1;
`endif
  assign pts_sum = {1'b0, points} + 17'(base_q);
  assign tot_sum = {1'b0, total_lines} + 11'(n_q);
  assign lil_sum = {1'b0, lines_in_level} + 7'(n_q);
  assign clr_ready = state == IDLE;
  always_ff @(posedge CLOCK_50) begin
    if (!resetn || new_game) begin
      state <= IDLE;
      n_q <= '0;
      base_q <= '0;
      iter <= '0;
      lines_in_level <= '0;
      score <= '0;
      level <= '0;
      total_lines <= '0;
      points <= '0;
      level_up <= 1'b0;
`ifdef SCORE_LEVEL_B2B_EN
      b2b <= 1'b0;
`endif
    end else begin
      level_up <= 1'b0;
      case (state)
        IDLE: if (clr_valid && n_in != 3'd0) begin
          n_q <= n_in;
          base_q <= base_in;
          iter <= level + 3'd1;
          state <= ADD;
        end
        ADD: begin
          points <= pts_sum[16] ? 16'hffff : pts_sum[15:0];
          iter <= iter - 3'd1;
          if (iter == 3'd1) state <= UPD;
        end
        UPD: begin
          total_lines <= tot_sum[10] ? 10'h3ff : tot_sum[9:0];
          if (level < 3'(MAX_LEVEL) && lil_sum >= 7'(LINES_PER_LEVEL)) begin
            level <= level + 3'd1;
            score <= {score[3:0], 1'b1};
            lines_in_level <= 6'(lil_sum - 7'(LINES_PER_LEVEL));
            level_up <= 1'b1;
          end else
            lines_in_level <= lil_sum > 7'(LINES_PER_LEVEL - 1) ? 6'(LINES_PER_LEVEL - 1) : 6'(lil_sum);
`ifdef SCORE_LEVEL_B2B_EN
          b2b <= n_q == 3'd4;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_score_level.sv
// tb_score_level: randomized reports checked against a transaction-level scoring model.
module tb_score_level;
  localparam int LPL = 10;
  logic CLOCK_50 = 0, resetn = 0, new_game = 0, clr_valid = 0;
  logic [2:0] clr_lines = 0;
  logic clr_ready, level_up;
  logic [4:0] score;
  logic [2:0] level;
  logic [9:0] total_lines;
  logic [15:0] points;
  int checks = 0, failures = 0;
  int m_cum = 0, m_total = 0, m_points = 0;
  bit m_b2b = 0;
  always #10 CLOCK_50 = ~CLOCK_50;
  score_level #(.LINES_PER_LEVEL(LPL)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .new_game(new_game), .clr_valid(clr_valid),
    .clr_lines(clr_lines), .clr_ready(clr_ready), .score(score), .level(level),
    .total_lines(total_lines), .points(points), .level_up(level_up)
  );
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int min_i(int a, int b);
    return a < b ? a : b;
  endfunction
  function automatic int m_level();
    return min_i(m_cum / LPL, 5);
  endfunction
  task automatic check_idle(string tag, int up);
    check({tag, "_ready"}, clr_ready, 1);
    check({tag, "_level"}, level, m_level());
    check({tag, "_score"}, score, (1 << m_level()) - 1);
    check({tag, "_total"}, total_lines, m_total);
    check({tag, "_points"}, points, m_points);
    check({tag, "_up"}, level_up, up);
  endtask
  task automatic model_clear();
    m_cum = 0;
    m_total = 0;
    m_points = 0;
    m_b2b = 0;
  endtask
  task automatic clear_game(bit with_valid);
    new_game = 1;
    clr_valid = with_valid;
    clr_lines = 3'd4;
    @(negedge CLOCK_50);
    new_game = 0;
    clr_valid = 0;
    model_clear();
    check_idle("clear", 0);
  endtask
  // abort_k: -1 never, -2 random 1-in-20, otherwise the busy cycle to abort in
  task automatic report(int raw, int abort_k);
    int n, lv, base, p0, ak;
    n = raw > 4 ? 4 : raw;
    lv = m_level();
    p0 = m_points;
    base = n == 4 ? 8 : 2 * n - 1;
`ifdef SCORE_LEVEL_B2B_EN
    if (n == 4 && m_b2b) base = 12;
`endif
    ak = abort_k == -2 ? ($urandom_range(0, 19) == 0 ? int'($urandom_range(0, lv + 1)) : -1) : abort_k;
    check("pre_ready", clr_ready, 1);
    clr_valid = 1;
    clr_lines = 3'(raw);
    @(negedge CLOCK_50);
    if (n == 0) begin
      clr_valid = 0;
      check_idle("zero", 0);
      return;
    end
    for (int k = 0; k <= lv + 1; k++) begin
      if (k > 0) @(negedge CLOCK_50);
      check("busy_ready", clr_ready, 0);
      check("busy_up", level_up, 0);
      check("add_points", points, min_i(p0 + k * base, 65535));
      clr_valid = k < lv + 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      clr_lines = 3'($urandom);
      if (k == ak) begin
        new_game = 1;
        clr_valid = 0;
        @(negedge CLOCK_50);
        new_game = 0;
        model_clear();
        check_idle("abort", 0);
        return;
      end
    end
    @(negedge CLOCK_50);
    m_cum += n;
    m_total = min_i(m_total + n, 1023);
    m_points = min_i(p0 + (lv + 1) * base, 65535);
    m_b2b = n == 4;
    check_idle("done", m_level() > lv ? 1 : 0);
    @(negedge CLOCK_50);
    check("up_pulse_end", level_up, 0);
  endtask
  initial begin
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    check_idle("reset", 0);
    resetn = 1;
    report(1, -1);
    check("single_points", points, 1);
    check("single_total", total_lines, 1);
    report(0, -1);
    clear_game(1'b1);
    report(4, -1);
    report(4, -1);
`ifdef SCORE_LEVEL_B2B_EN
    check("b2b_points", points, 20);
`endif
    report(2, -1);
    check("step_level", level, 1);
    check("step_score", score, 5'b00001);
`ifndef SCORE_LEVEL_B2B_EN
    check("step_points", points, 19);
    report(4, -1);
    check("after_step_points", points, 35);
`endif
    clear_game(1'b0);
    for (int i = 0; i < 8; i++) report(7, -1);
    check("pre_abort_level", level, 3);
    report(4, 2);
    for (int i = 0; i < 300; i++) report($urandom_range(0, 7), -2);
    clear_game(1'b0);
    for (int i = 0; i < 1400; i++) report(7, -1);
    check("sat_level", level, 5);
    check("sat_score", score, 5'b11111);
    check("sat_total", total_lines, 1023);
    check("sat_points", points, 65535);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
